sys_bus_ctrl: RTL

//  Single-master system bus slave-side controller; consumes bus_* signals from the pipelined CPU datapath.

---
 rtl/sys_bus_pkg.sv | 51 +++++
 rtl/sys_bus_if.sv | 13 +
 rtl/sys_bus_ctrl_uart_tx.sv | 75 +++++++
 rtl/sys_bus_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// rtl/sys_bus_pkg.sv - bus control encodings, address map, UART state type
// Shared by sys_bus_ctrl and uart_tx.
package sys_bus_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;
  localparam logic [2:0] RD_LWU  = 3'b110;
  localparam logic [2:0] RD_LD   = 3'b111;

  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] WR_SB   = 3'b001;
  localparam logic [2:0] WR_SH   = 3'b010;
  localparam logic [2:0] WR_SW   = 3'b011;
  localparam logic [2:0] WR_SD   = 3'b100;

  localparam logic [63:0] UART_TXDATA  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] UART_STATUS  = 64'h0000_0000_1000_0008;
  localparam logic [63:0] TIMER_BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam logic [63:0] MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  // size is log2 of the access width in bytes
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      2'd1:    misaligned = lane[0];
      2'd2:    misaligned = |lane[1:0];
      2'd3:    misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] timer_merge(input logic [63:0] old, input logic [2:0] wr,
                                              input logic hi, input logic [63:0] din);
    timer_merge = old;
    if (wr == WR_SD) timer_merge = din;
    else if (hi)     timer_merge[63:32] = din[31:0];
    else             timer_merge[31:0] = din[31:0];
  endfunction

endpackage

// File: rtl/sys_bus_if.sv
// rtl/sys_bus_if.sv - CPU datapath to bus controller signal bundle
// master = CPU datapath, slave = sys_bus_ctrl.
interface sys_bus_if;
  logic [2:0]  bus_rd_ctrl;
  logic [2:0]  bus_wr_ctrl;
  logic [63:0] bus_addr;
  logic [63:0] bus_din;
  logic [63:0] bus_dout;
  logic        bus_err;

  modport master (output bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din, input bus_dout, bus_err);
  modport slave  (input bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din, output bus_dout, bus_err);
endinterface

// File: rtl/sys_bus_ctrl_uart_tx.sv
// rtl/sys_bus_ctrl_uart_tx.sv - 8N1 UART transmitter, LSB first
// Each of START, 8 DATA bits and STOP lasts CLKS_PER_BIT clocks.
module uart_tx
  import sys_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_t   state, state_nx;
  logic [BW-1:0] baud, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          baud_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= UART_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    baud_nx   = baud;
    bit_nx    = bit_idx;
    shreg_nx  = shreg;
    baud_done = (baud == BW'(CLKS_PER_BIT - 1));
    if (state != UART_IDLE) baud_nx = baud_done ? '0 : baud + 1'b1;
    case (state)
      UART_IDLE: begin
        if (start) begin
          state_nx = UART_START;
          baud_nx  = '0;
          shreg_nx = data;
        end
      end
      UART_START: begin
        if (baud_done) begin
          state_nx = UART_DATA;
          bit_nx   = '0;
        end
      end
      UART_DATA: begin
        if (baud_done) begin
          shreg_nx = shreg >> 1;
          bit_nx   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = UART_STOP;
        end
      end
      UART_STOP: begin
        if (baud_done) state_nx = UART_IDLE;
      end
      default: state_nx = UART_IDLE;
    endcase
  end

  assign busy = (state != UART_IDLE);
  assign txd  = (state == UART_START) ? 1'b0 : (state == UART_DATA) ? shreg[0] : 1'b1;

endmodule

// File: rtl/sys_bus_ctrl.sv
// rtl/sys_bus_ctrl.sv - bus slave: address decode, load align/extend, store strobes, UART/timer MMIO
// Machine timer is built only when SYS_BUS_TIMER_EN is defined.
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int RAM_ADDR_W   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMER_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sys_bus_if.slave              bus,
  output logic [RAM_ADDR_W-4:0] ram_addr,
  output logic [63:0]           ram_wdata,
  output logic [7:0]            ram_wstrb,
  input  logic [63:0]           ram_rdata,
  output logic                  uart_txd,
  output logic                  timer_irq
);
  logic        wr_act, rd_act, err, we;
  logic [1:0]  size;
  logic [2:0]  lane;
  logic        hit_ram, hit_tx, hit_st, hit_cmp, hit_mtime;
  logic [63:0] rsrc, shifted;
  logic        uart_busy, overrun;
  logic [63:0] mtime, mtimecmp;

  assign lane     = bus.bus_addr[2:0];
  assign ram_addr = bus.bus_addr[RAM_ADDR_W-1:3];

  always_comb begin
    wr_act = 1'b1;
    size   = 2'd3;
    case (bus.bus_wr_ctrl)
      WR_SB:   size = 2'd0;
      WR_SH:   size = 2'd1;
      WR_SW:   size = 2'd2;
      WR_SD:   size = 2'd3;
      default: wr_act = 1'b0;
    endcase
    rd_act = !wr_act && (bus.bus_rd_ctrl != RD_NONE);
    if (!wr_act) begin
      case (bus.bus_rd_ctrl)
        RD_LB, RD_LBU: size = 2'd0;
        RD_LH, RD_LHU: size = 2'd1;
        RD_LW, RD_LWU: size = 2'd2;
        default:       size = 2'd3;
      endcase
    end
  end

  always_comb begin
    hit_ram = (bus.bus_addr[63:RAM_ADDR_W] == '0);
    hit_tx  = (bus.bus_addr[63:3] == UART_TXDATA[63:3]);
    hit_st  = (bus.bus_addr[63:3] == UART_STATUS[63:3]);
`ifdef SYS_BUS_TIMER_EN
    hit_cmp   = (bus.bus_addr[63:3] == 61'((TIMER_BASE + MTIMECMP_OFF) >> 3));
    hit_mtime = (bus.bus_addr[63:3] == 61'((TIMER_BASE + MTIME_OFF) >> 3));
`else
    hit_cmp   = 1'b0;
    hit_mtime = 1'b0;
`endif
    err = (wr_act || rd_act) &&
          (misaligned(size, lane) || !(hit_ram || hit_tx || hit_st || hit_cmp || hit_mtime));
    we  = wr_act && !err;
  end

  always_comb begin
    rsrc = '0;
    if (hit_ram)        rsrc = ram_rdata;
    else if (hit_st)    rsrc = {62'b0, overrun, uart_busy};
    else if (hit_cmp)   rsrc = mtimecmp;
    else if (hit_mtime) rsrc = mtime;
    shifted = rsrc >> {lane, 3'b000};

    bus.bus_err  = err;
    bus.bus_dout = '0;
    if (!wr_act && !rd_act) begin
      bus.bus_dout = {32'b0, bus.bus_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0]};
    end else if (rd_act && !err) begin
      case (bus.bus_rd_ctrl)
        RD_LB:   bus.bus_dout = {{56{shifted[7]}}, shifted[7:0]};
        RD_LBU:  bus.bus_dout = {56'b0, shifted[7:0]};
        RD_LH:   bus.bus_dout = {{48{shifted[15]}}, shifted[15:0]};
        RD_LHU:  bus.bus_dout = {48'b0, shifted[15:0]};
        RD_LW:   bus.bus_dout = {{32{shifted[31]}}, shifted[31:0]};
        RD_LWU:  bus.bus_dout = {32'b0, shifted[31:0]};
        default: bus.bus_dout = shifted;
      endcase
    end
  end

  // Replication puts the store data into every lane; the strobe picks the real ones.
  always_comb begin
    case (bus.bus_wr_ctrl)
      WR_SB:   ram_wdata = {8{bus.bus_din[7:0]}};
      WR_SH:   ram_wdata = {4{bus.bus_din[15:0]}};
      WR_SW:   ram_wdata = {2{bus.bus_din[31:0]}};
      default: ram_wdata = bus.bus_din;
    endcase
    ram_wstrb = '0;
    if (we && hit_ram && rst) begin
      case (size)
        2'd0:    ram_wstrb = 8'h01 << lane;
        2'd1:    ram_wstrb = 8'h03 << lane;
        2'd2:    ram_wstrb = 8'h0F << lane;
        default: ram_wstrb = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           overrun <= 1'b0;
    else if (we && hit_st)              overrun <= 1'b0;
    else if (we && hit_tx && uart_busy) overrun <= 1'b1;
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .clk   (clk),
    .rst   (rst),
    .start (we && hit_tx && !uart_busy),
    .data  (bus.bus_din[7:0]),
    .busy  (uart_busy),
    .txd   (uart_txd)
  );

`ifdef SYS_BUS_TIMER_EN
  logic [31:0] prescale;
  logic        tick, tmr_wr;

  assign tick   = (prescale == 32'(TIMER_DIV - 1));
  assign tmr_wr = we && ((bus.bus_wr_ctrl == WR_SD) || (bus.bus_wr_ctrl == WR_SW));

  // A CPU write to mtime takes priority over the increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale  <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      prescale  <= tick ? '0 : prescale + 32'd1;
      timer_irq <= (mtime >= mtimecmp);
      if (tmr_wr && hit_mtime) mtime <= timer_merge(mtime, bus.bus_wr_ctrl, bus.bus_addr[2], bus.bus_din);
      else if (tick)           mtime <= mtime + 64'd1;
      if (tmr_wr && hit_cmp)   mtimecmp <= timer_merge(mtimecmp, bus.bus_wr_ctrl, bus.bus_addr[2], bus.bus_din);
    end
  end
`else
  assign mtime     = '0;
  assign mtimecmp  = '1;
  assign timer_irq = 1'b0;
`endif

endmodule
